// File: rtl/hazard_ctrl_if.sv
// Pipeline-control bundle between the RV32I datapath and hazard_ctrl.
// The datapath (master) drives hazard inputs; hazard_ctrl (slave) returns
// pipeline-register enables, flushes, status and performance counters.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_redirect;
  logic             mem_req;
  logic             mem_ready;
  logic             halt_req;
  logic             pc_write;
  logic             pc_sel_redirect;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_write;
  logic             id_ex_flush;
  logic             ex_mem_write;
  logic             mem_wb_flush;
  logic             halted;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_redirect, mem_req, mem_ready, halt_req,
    input  pc_write, pc_sel_redirect, if_id_write, if_id_flush, id_ex_write,
           id_ex_flush, ex_mem_write, mem_wb_flush, halted, mem_timeout,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_redirect, mem_req, mem_ready, halt_req,
    output pc_write, pc_sel_redirect, if_id_write, if_id_flush, id_ex_write,
           id_ex_flush, ex_mem_write, mem_wb_flush, halted, mem_timeout,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Central pipeline control for the 5-stage RV32I core: load-use stalls,
// EX redirects, data-memory wait states, drain/halt, and saturating
// stall/flush counters with a sticky memory-timeout flag.
// Control outputs are combinational so pipeline registers act on them at
// the following edge; state, counters and the timeout flag are registered.
module hazard_ctrl #(
  parameter int CNT_W        = 16,
  parameter int MEM_TIMEOUT  = 64,
  parameter int DRAIN_CYCLES = 4
) (
  input logic          clk,
  input logic          rst_n,
  hazard_ctrl_if.slave hz
);

  localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } state_t;

  state_t             state_r, state_nx_s;
  logic [WAIT_W-1:0]  wait_cnt_r, wait_cnt_nx_s;
  logic [DRAIN_W-1:0] drain_cnt_r, drain_cnt_nx_s;
  logic [CNT_W-1:0]   stall_cnt_r, flush_cnt_r;
  logic               mem_timeout_r, timeout_set_s;
  logic               load_use_s, mem_stall_s;
  logic               pc_write_s, pc_sel_redirect_s, if_id_write_s, if_id_flush_s;
  logic               id_ex_write_s, id_ex_flush_s, ex_mem_write_s, mem_wb_flush_s;
  logic               halted_s;

  // A source operand read in ID that the load in EX is about to produce.
  function automatic logic src_hit(input logic use_src, input logic [4:0] rs,
                                   input logic [4:0] rd);
    return use_src & (rs == rd);
  endfunction

  assign load_use_s  = hz.ex_mem_read & (hz.ex_rd != 5'd0) &
                       (src_hit(hz.id_use_rs1, hz.id_rs1, hz.ex_rd) |
                        src_hit(hz.id_use_rs2, hz.id_rs2, hz.ex_rd));
  assign mem_stall_s = hz.mem_req & ~hz.mem_ready;

  // Next-state, wait/drain counter and pipeline-control decode.
  always_comb begin
    state_nx_s        = state_r;
    wait_cnt_nx_s     = {WAIT_W{1'b0}};
    drain_cnt_nx_s    = drain_cnt_r;
    timeout_set_s     = 1'b0;
    pc_write_s        = 1'b1;
    pc_sel_redirect_s = 1'b0;
    if_id_write_s     = 1'b1;
    if_id_flush_s     = 1'b0;
    id_ex_write_s     = 1'b1;
    id_ex_flush_s     = 1'b0;
    ex_mem_write_s    = 1'b1;
    mem_wb_flush_s    = 1'b0;
    halted_s          = 1'b0;
    case (state_r)
      ST_RUN, ST_MEM_WAIT: begin
        drain_cnt_nx_s = {DRAIN_W{1'b0}};
        if (mem_stall_s) begin
          // Freeze everything up to MEM; redirect/load-use re-present later.
          pc_write_s     = 1'b0;
          if_id_write_s  = 1'b0;
          id_ex_write_s  = 1'b0;
          ex_mem_write_s = 1'b0;
          mem_wb_flush_s = 1'b1;
          state_nx_s     = ST_MEM_WAIT;
          if (state_r == ST_MEM_WAIT) begin
            if (wait_cnt_r < WAIT_W'(MEM_TIMEOUT)) begin
              wait_cnt_nx_s = wait_cnt_r + WAIT_W'(1);
            end else begin
              wait_cnt_nx_s = wait_cnt_r;
            end
            timeout_set_s = (wait_cnt_nx_s == WAIT_W'(MEM_TIMEOUT));
          end else begin
            wait_cnt_nx_s = {WAIT_W{1'b0}};
          end
        end else begin
          state_nx_s = hz.halt_req ? ST_DRAIN : ST_RUN;
          if (hz.ex_redirect) begin
            pc_sel_redirect_s = 1'b1;
            if_id_flush_s     = 1'b1;
            id_ex_flush_s     = 1'b1;
          end else if (load_use_s) begin
            pc_write_s    = 1'b0;
            if_id_write_s = 1'b0;
            id_ex_flush_s = 1'b1;
          end else begin
            pc_write_s = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        pc_write_s    = 1'b0;
        if_id_flush_s = 1'b1;
        if (mem_stall_s) begin
          if_id_write_s  = 1'b0;
          id_ex_write_s  = 1'b0;
          ex_mem_write_s = 1'b0;
          mem_wb_flush_s = 1'b1;
        end else begin
          mem_wb_flush_s = 1'b0;
        end
        if (!hz.halt_req) begin
          state_nx_s     = ST_RUN;
          drain_cnt_nx_s = {DRAIN_W{1'b0}};
        end else if (mem_stall_s) begin
          drain_cnt_nx_s = drain_cnt_r;
        end else if (drain_cnt_r == DRAIN_W'(DRAIN_CYCLES - 1)) begin
          state_nx_s     = ST_HALTED;
          drain_cnt_nx_s = {DRAIN_W{1'b0}};
        end else begin
          drain_cnt_nx_s = drain_cnt_r + DRAIN_W'(1);
        end
      end
      ST_HALTED: begin
        halted_s       = 1'b1;
        pc_write_s     = 1'b0;
        if_id_flush_s  = 1'b1;
        drain_cnt_nx_s = {DRAIN_W{1'b0}};
        state_nx_s     = hz.halt_req ? ST_HALTED : ST_RUN;
      end
      default: begin
        state_nx_s     = ST_RUN;
        drain_cnt_nx_s = {DRAIN_W{1'b0}};
      end
    endcase
  end

  // State, wait/drain counters and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_RUN;
      wait_cnt_r    <= {WAIT_W{1'b0}};
      drain_cnt_r   <= {DRAIN_W{1'b0}};
      mem_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      wait_cnt_r    <= wait_cnt_nx_s;
      drain_cnt_r   <= drain_cnt_nx_s;
      mem_timeout_r <= mem_timeout_r | timeout_set_s;
    end
  end

  // Saturating performance counters for stalled-PC and IF/ID-flush cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (!pc_write_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (if_id_flush_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign hz.pc_write        = pc_write_s;
  assign hz.pc_sel_redirect = pc_sel_redirect_s;
  assign hz.if_id_write     = if_id_write_s;
  assign hz.if_id_flush     = if_id_flush_s;
  assign hz.id_ex_write     = id_ex_write_s;
  assign hz.id_ex_flush     = id_ex_flush_s;
  assign hz.ex_mem_write    = ex_mem_write_s;
  assign hz.mem_wb_flush    = mem_wb_flush_s;
  assign hz.halted          = halted_s;
  assign hz.mem_timeout     = mem_timeout_r;
  assign hz.stall_cnt       = stall_cnt_r;
  assign hz.flush_cnt       = flush_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, redirect, memory wait, timeout,
// drain/halt, counter saturation and asynchronous reset mid-wait.
module tb_hazard_ctrl;

  localparam int CNT_W = 4;

  // Control vector order:
  // {pc_write, pc_sel_redirect, if_id_write, if_id_flush, id_ex_write,
  //  id_ex_flush, ex_mem_write, mem_wb_flush, halted}
  localparam logic [8:0] C_DEF   = 9'b101010100;
  localparam logic [8:0] C_LU    = 9'b000011100;
  localparam logic [8:0] C_REDIR = 9'b111111100;
  localparam logic [8:0] C_MSTL  = 9'b000000010;
  localparam logic [8:0] C_DRAIN = 9'b001110100;
  localparam logic [8:0] C_HALT  = 9'b001110101;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  hazard_ctrl #(
    .CNT_W(CNT_W),
    .MEM_TIMEOUT(4),
    .DRAIN_CYCLES(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (hz.slave)
  );

  logic [8:0] ctl;
  assign ctl = {hz.pc_write, hz.pc_sel_redirect, hz.if_id_write, hz.if_id_flush,
                hz.id_ex_write, hz.id_ex_flush, hz.ex_mem_write, hz.mem_wb_flush,
                hz.halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hz.id_rs1 = 5'd0;  hz.id_rs2 = 5'd0;
    hz.id_use_rs1 = 1'b0; hz.id_use_rs2 = 1'b0;
    hz.ex_rd = 5'd0; hz.ex_mem_read = 1'b0; hz.ex_redirect = 1'b0;
    hz.mem_req = 1'b0; hz.mem_ready = 1'b0; hz.halt_req = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    clear_inputs();
    #3;
    chk("reset_ctl", 32'(ctl), 32'(C_DEF));
    chk("reset_stall_cnt", 32'(hz.stall_cnt), 32'd0);
    chk("reset_flush_cnt", 32'(hz.flush_cnt), 32'd0);
    chk("reset_timeout", 32'(hz.mem_timeout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Load-use on rs1 = x5.
    hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd5; hz.id_use_rs1 = 1'b1; hz.id_rs1 = 5'd5;
    #1 chk("load_use_ctl", 32'(ctl), 32'(C_LU));
    tick();
    clear_inputs();
    #1 chk("after_load_use_ctl", 32'(ctl), 32'(C_DEF));
    chk("load_use_stall_cnt", 32'(hz.stall_cnt), 32'd1);

    // Load to x0 never stalls.
    hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd0; hz.id_use_rs1 = 1'b1; hz.id_rs1 = 5'd0;
    #1 chk("x0_no_stall_ctl", 32'(ctl), 32'(C_DEF));
    tick();
    clear_inputs();
    #1 chk("x0_stall_cnt", 32'(hz.stall_cnt), 32'd1);

    // Redirect wins over a simultaneous load-use (rs2 match).
    hz.ex_redirect = 1'b1; hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd7;
    hz.id_use_rs2 = 1'b1; hz.id_rs2 = 5'd7;
    #1 chk("redirect_ctl", 32'(ctl), 32'(C_REDIR));
    tick();
    clear_inputs();
    #1 chk("redirect_flush_cnt", 32'(hz.flush_cnt), 32'd1);
    chk("redirect_stall_cnt", 32'(hz.stall_cnt), 32'd1);

    // Memory wait for 3 cycles with redirect held high.
    hz.mem_req = 1'b1; hz.mem_ready = 1'b0; hz.ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("mem_wait_ctl", 32'(ctl), 32'(C_MSTL));
      tick();
    end
    hz.mem_ready = 1'b1;
    #1 chk("mem_ready_redirect_ctl", 32'(ctl), 32'(C_REDIR));
    tick();
    clear_inputs();
    #1 chk("mem_wait_stall_cnt", 32'(hz.stall_cnt), 32'd4);
    chk("mem_wait_flush_cnt", 32'(hz.flush_cnt), 32'd2);
    chk("mem_wait_no_timeout", 32'(hz.mem_timeout), 32'd0);

    // Timeout: stall 6 cycles (1 in RUN, then 5 in MEM_WAIT).
    hz.mem_req = 1'b1; hz.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("timeout_after_3_waits", 32'(hz.mem_timeout), 32'd0);
    tick();
    chk("timeout_after_4_waits", 32'(hz.mem_timeout), 32'd1);
    tick();
    hz.mem_ready = 1'b1;
    tick();
    clear_inputs();
    #1 chk("timeout_sticky", 32'(hz.mem_timeout), 32'd1);
    chk("timeout_stall_cnt", 32'(hz.stall_cnt), 32'd10);
    chk("timeout_flush_cnt", 32'(hz.flush_cnt), 32'd2);

    // Halt: request cycle in RUN, 4 drain cycles, then halted.
    hz.halt_req = 1'b1;
    #1 chk("halt_req_run_ctl", 32'(ctl), 32'(C_DEF));
    tick();
    for (int i = 0; i < 4; i++) begin
      hz.ex_redirect = (i == 1);
      #1 chk("drain_ctl", 32'(ctl), 32'(C_DRAIN));
      tick();
    end
    hz.ex_redirect = 1'b0;
    #1 chk("halted_ctl", 32'(ctl), 32'(C_HALT));
    tick();
    chk("halted_hold_ctl", 32'(ctl), 32'(C_HALT));
    tick();
    chk("halt_stall_cnt_sat", 32'(hz.stall_cnt), 32'd15);
    chk("halt_flush_cnt", 32'(hz.flush_cnt), 32'd8);
    hz.halt_req = 1'b0;
    #1 chk("halted_release_ctl", 32'(ctl), 32'(C_HALT));
    tick();
    chk("resume_run_ctl", 32'(ctl), 32'(C_DEF));
    chk("resume_flush_cnt", 32'(hz.flush_cnt), 32'd9);
    chk("resume_stall_cnt_sat", 32'(hz.stall_cnt), 32'd15);

    // Asynchronous reset in the middle of a memory wait.
    hz.mem_req = 1'b1; hz.mem_ready = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1 chk("async_rst_stall_cnt", 32'(hz.stall_cnt), 32'd0);
    chk("async_rst_flush_cnt", 32'(hz.flush_cnt), 32'd0);
    chk("async_rst_timeout", 32'(hz.mem_timeout), 32'd0);
    clear_inputs();
    #1 chk("async_rst_ctl", 32'(ctl), 32'(C_DEF));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ctl", 32'(ctl), 32'(C_DEF));
    chk("post_rst_stall_cnt", 32'(hz.stall_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
